// File: rtl/irom_boot_loader_pkg.sv
// Shared state and error encodings for the IROM boot loader.
package irom_boot_loader_pkg;

    typedef enum logic [2:0] {
        BL_IDLE    = 3'd0,
        BL_HDR     = 3'd1,
        BL_DATA    = 3'd2,
        BL_CSUM    = 3'd3,
        BL_RELEASE = 3'd4,
        BL_RUN     = 3'd5,
        BL_ERROR   = 3'd6
    } bl_state_e;

    typedef enum logic [1:0] {
        BL_ERR_NONE    = 2'd0,
        BL_ERR_LEN     = 2'd1,
        BL_ERR_CSUM    = 2'd2,
        BL_ERR_TIMEOUT = 2'd3
    } bl_err_e;

    // States in which the host link is being consumed
    function automatic logic bl_is_loading(input bl_state_e s);
        return (s == BL_HDR) || (s == BL_DATA) || (s == BL_CSUM);
    endfunction

    function automatic logic bl_can_start(input bl_state_e s);
        return (s == BL_IDLE) || (s == BL_RUN) || (s == BL_ERROR);
    endfunction

endpackage

// File: rtl/irom_boot_loader_le_word_packer.sv
// Packs a byte stream into little-endian 32-bit words; word_valid_o fires with the 4th byte.
module le_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        valid_i,
    input  logic [7:0]  data_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q;
    logic [23:0] shift_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (valid_i) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {data_i, shift_q[23:8]};
        end
    end

    // Earlier bytes have shifted down, so the incoming byte lands in the MSB lane
    assign word_o       = {data_i, shift_q};
    assign word_valid_o = valid_i && (cnt_q == 2'd3);

endmodule

// File: rtl/irom_boot_loader.sv
// Boot sequencer: loads a length-prefixed, checksummed image into IROM and releases the core.
module irom_boot_loader
    import irom_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter logic [31:0] BOOT_ADDR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              setup,
    output logic              irom_wr_en,
    output logic [ADDR_W-1:0] irom_wr_addr,
    output logic [31:0]       irom_wr_data,
    output logic              pc_load,
    output logic [31:0]       pc_first_addr,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    localparam int unsigned       IDLE_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]       MAX_WORDS = 32'(1) << ADDR_W;

    bl_state_e           state_q, state_d;
    bl_err_e             err_q, err_d;
    logic [7:0]          sum_q;
    logic [ADDR_W:0]     n_q;
    logic [ADDR_W-1:0]   widx_q;
    logic [IDLE_W-1:0]   idle_q;
    logic                rx_ready_q, setup_q, busy_q, done_q, pc_load_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [31:0]         wr_data_q;

    logic                accept, pack_valid, restart, timeout, last_word;
    logic [31:0]         pack_word;
    logic                pack_word_valid;

    assign accept     = rx_valid && rx_ready_q;
    assign pack_valid = accept && ((state_q == BL_HDR) || (state_q == BL_DATA));
    assign restart    = start && bl_can_start(state_q);
    assign timeout    = bl_is_loading(state_q) && !accept && (idle_q == IDLE_LAST);
    assign last_word  = ({1'b0, widx_q} == (n_q - (ADDR_W+1)'(1)));

    // Header and data share one packer: the header is just the first packed word
    le_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (restart),
        .valid_i      (pack_valid),
        .data_i       (rx_data),
        .word_o       (pack_word),
        .word_valid_o (pack_word_valid)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            BL_IDLE: if (start) state_d = BL_HDR;
            BL_HDR: begin
                if (pack_word_valid) begin
                    if (pack_word > MAX_WORDS) begin
                        state_d = BL_ERROR;
                        err_d   = BL_ERR_LEN;
                    end else if (pack_word == 32'd0) begin
                        state_d = BL_CSUM;
                    end else begin
                        state_d = BL_DATA;
                    end
                end else if (timeout) begin
                    state_d = BL_ERROR;
                    err_d   = BL_ERR_TIMEOUT;
                end
            end
            BL_DATA: begin
                if (pack_word_valid && last_word) begin
                    state_d = BL_CSUM;
                end else if (timeout) begin
                    state_d = BL_ERROR;
                    err_d   = BL_ERR_TIMEOUT;
                end
            end
            BL_CSUM: begin
                if (accept) begin
                    if (rx_data == sum_q) begin
                        state_d = BL_RELEASE;
                    end else begin
                        state_d = BL_ERROR;
                        err_d   = BL_ERR_CSUM;
                    end
                end else if (timeout) begin
                    state_d = BL_ERROR;
                    err_d   = BL_ERR_TIMEOUT;
                end
            end
            BL_RELEASE: state_d = BL_RUN;
            BL_RUN:     if (start) state_d = BL_HDR;
            BL_ERROR: begin
                if (start) begin
                    state_d = BL_HDR;
                    err_d   = BL_ERR_NONE;
                end
            end
            default: state_d = BL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BL_IDLE;
            err_q      <= BL_ERR_NONE;
            sum_q      <= '0;
            n_q        <= '0;
            widx_q     <= '0;
            idle_q     <= '0;
            rx_ready_q <= 1'b0;
            setup_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pc_load_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            // Level outputs follow the state being entered, so they stay registered
            rx_ready_q <= bl_is_loading(state_d);
            busy_q     <= bl_is_loading(state_d);
            setup_q    <= (state_d != BL_RUN);
            done_q     <= (state_d == BL_RUN);
            pc_load_q  <= (state_d == BL_RELEASE);
            wr_en_q    <= 1'b0;

            if (restart) begin
                sum_q     <= '0;
                widx_q    <= '0;
                idle_q    <= '0;
                wr_addr_q <= '0;
            end else if (bl_is_loading(state_q)) begin
                idle_q <= accept ? '0 : idle_q + IDLE_W'(1);
                if (pack_valid) sum_q <= sum_q + rx_data;
                if (pack_word_valid && (state_q == BL_HDR)) n_q <= pack_word[ADDR_W:0];
                if (pack_word_valid && (state_q == BL_DATA)) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= widx_q;
                    wr_data_q <= pack_word;
                    widx_q    <= widx_q + ADDR_W'(1);
                end
            end
        end
    end

    assign rx_ready      = rx_ready_q;
    assign setup         = setup_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pc_load       = pc_load_q;
    assign irom_wr_en    = wr_en_q;
    assign irom_wr_addr  = wr_addr_q;
    assign irom_wr_data  = wr_data_q;
    assign err           = err_q;
    assign pc_first_addr = BOOT_ADDR;

endmodule

// File: tb/tb_irom_boot_loader.sv
// Directed bench for irom_boot_loader: normal, bad checksum, length, zero, timeout, reset.
module tb_irom_boot_loader;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst, start, rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready, setup, irom_wr_en, pc_load, busy, done;
    logic [ADDR_W-1:0] irom_wr_addr;
    logic [31:0]       irom_wr_data, pc_first_addr;
    logic [1:0]        err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int unsigned pc_cnt = 0;
    logic [31:0] pc_addr_seen = '1;

    irom_boot_loader #(
        .ADDR_W      (ADDR_W),
        .BOOT_ADDR   (32'h0000_0000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .setup         (setup),
        .irom_wr_en    (irom_wr_en),
        .irom_wr_addr  (irom_wr_addr),
        .irom_wr_data  (irom_wr_data),
        .pc_load       (pc_load),
        .pc_first_addr (pc_first_addr),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (irom_wr_en === 1'b1) begin
            wa.push_back(32'(irom_wr_addr));
            wd.push_back(irom_wr_data);
        end
        if (pc_load === 1'b1) begin
            pc_cnt++;
            pc_addr_seen = pc_first_addr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        pc_cnt = 0;
        pc_addr_seen = '1;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $error("FAIL accept_wait: observed rx_ready %b expected 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int unsigned maxgap);
        foreach (s[i]) send_byte(s[i], $urandom_range(maxgap, 0));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_image();
        check("n_writes", 32'(wa.size()), 32'd2);
        check("w0_addr", wa.size() > 0 ? wa[0] : 32'hx, 32'd0);
        check("w0_data", wd.size() > 0 ? wd[0] : 32'hx, 32'h0000_0013);
        check("w1_addr", wa.size() > 1 ? wa[1] : 32'hx, 32'd1);
        check("w1_data", wd.size() > 1 ? wd[1] : 32'hx, 32'h00A0_0093);
        check("pc_pulses", pc_cnt, 32'd1);
        check("pc_first_addr", pc_addr_seen, 32'd0);
        check("run_setup", 32'(setup), 32'd0);
        check("run_done", 32'(done), 32'd1);
        check("run_err", 32'(err), 32'd0);
        check("run_busy", 32'(busy), 32'd0);
        check("run_rx_ready", 32'(rx_ready), 32'd0);
    endtask

    logic [7:0] good[$];
    logic [7:0] bad[$];
    logic [7:0] s[$];

    initial begin
        good = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'hA0, 8'h00, 8'h48};
        bad  = good;
        bad[12] = 8'h47;
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(negedge clk);

        check("rst_setup", 32'(setup), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_wr_en", 32'(irom_wr_en), 32'd0);
        check("rst_wr_addr", 32'(irom_wr_addr), 32'd0);
        check("rst_wr_data", irom_wr_data, 32'd0);
        check("rst_pc_load", 32'(pc_load), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_rx_ready", 32'(rx_ready), 32'd0);

        // Normal load, back-to-back bytes
        pulse_start();
        check("hdr_rx_ready", 32'(rx_ready), 32'd1);
        check("hdr_busy", 32'(busy), 32'd1);
        check("hdr_setup", 32'(setup), 32'd1);
        send_stream(good, 0);
        repeat (3) @(negedge clk);
        check_image();

        // Bad checksum from RUN
        pulse_start();
        check("restart_done", 32'(done), 32'd0);
        check("restart_setup", 32'(setup), 32'd1);
        clear_log();
        send_stream(bad, 0);
        repeat (3) @(negedge clk);
        check("bad_pc_pulses", pc_cnt, 32'd0);
        check("bad_setup", 32'(setup), 32'd1);
        check("bad_err", 32'(err), 32'd2);
        check("bad_done", 32'(done), 32'd0);
        check("bad_rx_ready", 32'(rx_ready), 32'd0);

        // Recovery with random gaps between bytes
        pulse_start();
        check("err_cleared", 32'(err), 32'd0);
        clear_log();
        send_stream(good, 5);
        repeat (3) @(negedge clk);
        check_image();

        // Length overflow: N = 1025
        pulse_start();
        clear_log();
        s = '{8'h01, 8'h04, 8'h00, 8'h00};
        send_stream(s, 0);
        repeat (2) @(negedge clk);
        check("len_err", 32'(err), 32'd1);
        check("len_writes", 32'(wa.size()), 32'd0);
        check("len_setup", 32'(setup), 32'd1);
        check("len_rx_ready", 32'(rx_ready), 32'd0);

        // Exactly 1024 words is accepted as a length
        pulse_start();
        s = '{8'h00, 8'h04, 8'h00, 8'h00};
        send_stream(s, 0);
        check("len_max_ok_err", 32'(err), 32'd0);
        check("len_max_ok_ready", 32'(rx_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Zero length
        pulse_start();
        clear_log();
        s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(s, 0);
        repeat (3) @(negedge clk);
        check("zero_writes", 32'(wa.size()), 32'd0);
        check("zero_pc_pulses", pc_cnt, 32'd1);
        check("zero_done", 32'(done), 32'd1);
        check("zero_err", 32'(err), 32'd0);

        // Timeout after 3 bytes, 16 idle cycles
        pulse_start();
        s = '{8'h02, 8'h00, 8'h00};
        send_stream(s, 0);
        repeat (15) @(negedge clk);
        check("to_not_yet_err", 32'(err), 32'd0);
        check("to_not_yet_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        check("to_err", 32'(err), 32'd3);
        check("to_rx_ready", 32'(rx_ready), 32'd0);
        check("to_setup", 32'(setup), 32'd1);

        // Mid-load reset after word 0
        pulse_start();
        clear_log();
        s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        send_stream(s, 0);
        @(negedge clk);
        check("mid_writes", 32'(wa.size()), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_setup", 32'(setup), 32'd1);
        check("mrst_rx_ready", 32'(rx_ready), 32'd0);
        check("mrst_wr_en", 32'(irom_wr_en), 32'd0);
        check("mrst_wr_data", irom_wr_data, 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fresh load from IDLE after the abort
        pulse_start();
        clear_log();
        send_stream(good, 3);
        repeat (3) @(negedge clk);
        check_image();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
